// File: rtl/memory_access_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : memory_access_controller_if
// Brief    : Request/response handshake and scratch-memory pin bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface memory_access_controller_if #(
    parameter int data_size = 8,
    parameter int address   = 4
);
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_write;
    logic [address-1:0]   req_addr;
    logic [data_size-1:0] req_wdata;

    logic                 rsp_valid;
    logic                 rsp_write;
    logic [data_size-1:0] rsp_rdata;
    logic                 rsp_err;

    logic                 mem_cs;
    logic                 mem_write_en;
    logic                 mem_read_en;
    logic [address-1:0]   mem_address;
    logic [data_size-1:0] mem_data_out;
    logic [data_size-1:0] mem_data_in;

    // Controller side
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, mem_data_in,
        output req_ready, rsp_valid, rsp_write, rsp_rdata, rsp_err,
               mem_cs, mem_write_en, mem_read_en, mem_address, mem_data_out
    );

    // Requester plus memory side
    modport master (
        output req_valid, req_write, req_addr, req_wdata, mem_data_in,
        input  req_ready, rsp_valid, rsp_write, rsp_rdata, rsp_err,
               mem_cs, mem_write_en, mem_read_en, mem_address, mem_data_out
    );
endinterface
`default_nettype wire

// File: rtl/memory_access_controller.sv
`default_nettype none
// ============================================================================
// Module   : memory_access_controller
// Brief    : Single-request initiator for the cs/write_en/read_en scratch
//            memory. Define MEM_CTRL_WVERIFY_EN to add write readback verify.
// Revision : 1.0 - initial release
// ============================================================================
module memory_access_controller #(
    parameter int data_size = 8,
    parameter int address   = 4
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    memory_access_controller_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WRITE  = 3'd1,
        S_FETCH  = 3'd2,
        S_DRIVE  = 3'd3
`ifdef MEM_CTRL_WVERIFY_EN
        ,
        S_VFETCH = 3'd4,
        S_VDRIVE = 3'd5
`endif
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [address-1:0]   r_addr;
    logic [data_size-1:0] r_wdata;
    logic                 r_rsp_valid;
    logic                 r_rsp_write;
    logic [data_size-1:0] r_rsp_rdata;
    logic                 w_req_ready;
    logic                 w_cs;
    logic                 w_write_en;
    logic                 w_read_en;
    logic                 w_capture;
    logic                 w_done;
    logic                 w_done_write;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    // All pin controls decode from the state register only
    always_comb begin
        w_next_state = r_state;
        w_req_ready  = 1'b0;
        w_cs         = 1'b1;
        w_write_en   = 1'b0;
        w_read_en    = 1'b0;
        w_capture    = 1'b0;
        w_done       = 1'b0;
        w_done_write = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_req_ready = 1'b1;
                w_cs        = 1'b0;
                if (bus.req_valid) w_next_state = bus.req_write ? S_WRITE : S_FETCH;
            end
            S_WRITE: begin
                w_write_en = 1'b1;
`ifdef MEM_CTRL_WVERIFY_EN
                w_next_state = S_VFETCH;
`else
                w_done       = 1'b1;
                w_done_write = 1'b1;
                w_next_state = S_IDLE;
`endif
            end
            S_FETCH: w_next_state = S_DRIVE;
            S_DRIVE: begin
                w_read_en    = 1'b1;
                w_capture    = 1'b1;
                w_done       = 1'b1;
                w_next_state = S_IDLE;
            end
`ifdef MEM_CTRL_WVERIFY_EN
            S_VFETCH: w_next_state = S_VDRIVE;
            S_VDRIVE: begin
                w_read_en    = 1'b1;
                w_capture    = 1'b1;
                w_done       = 1'b1;
                w_done_write = 1'b1;
                w_next_state = S_IDLE;
            end
`endif
            default: begin
                w_cs         = 1'b0;
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_write <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_rsp_valid <= w_done;
            r_rsp_write <= w_done_write;
            if (w_req_ready && bus.req_valid) begin
                r_addr  <= bus.req_addr;
                r_wdata <= bus.req_wdata;
            end
            if (w_capture) r_rsp_rdata <= bus.mem_data_in;
        end
    end

`ifdef MEM_CTRL_WVERIFY_EN
    logic r_rsp_err;

    always_ff @(posedge clk) begin
        if (rst) r_rsp_err <= 1'b0;
        else     r_rsp_err <= (r_state == S_VDRIVE) && (bus.mem_data_in != r_wdata);
    end

    assign bus.rsp_err = r_rsp_err;
`else
    assign bus.rsp_err = 1'b0;
`endif

    assign bus.req_ready    = w_req_ready;
    assign bus.rsp_valid    = r_rsp_valid;
    assign bus.rsp_write    = r_rsp_write;
    assign bus.rsp_rdata    = r_rsp_rdata;
    assign bus.mem_cs       = w_cs;
    assign bus.mem_write_en = w_write_en;
    assign bus.mem_read_en  = w_read_en;
    assign bus.mem_address  = r_addr;
    assign bus.mem_data_out = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_memory_access_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_memory_access_controller
// Brief    : Scoreboard bench with a behavioural two-phase scratch memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_memory_access_controller;
`ifdef MEM_CTRL_WVERIFY_EN
    localparam int WLAT = 3;
`else
    localparam int WLAT = 1;
`endif

    typedef struct {
        logic       wr;
        logic [7:0] rdata;
        bit         chk_rdata;
        logic       err;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];
    exp_t mon_e;
    logic [7:0] exp_mem [0:15];
    logic [7:0] mem     [0:15];
    logic [7:0] mem_latch;
    logic       corrupt = 1'b0;
    logic       acc_with_rsp;

    memory_access_controller_if #(.data_size(8), .address(4)) bus ();

    memory_access_controller #(.data_size(8), .address(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scratch memory: stores on write edge, loads latch in fetch, drives in read phase
    always @(posedge clk) begin
        if (bus.mem_cs && bus.mem_write_en) mem[bus.mem_address] <= bus.mem_data_out;
        if (bus.mem_cs && !bus.mem_write_en && !bus.mem_read_en) mem_latch <= mem[bus.mem_address];
    end
    assign bus.mem_data_in = (bus.mem_cs && bus.mem_read_en) ? (mem_latch ^ {7'd0, corrupt}) : 8'hzz;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (bus.rsp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("rsp_cycle", 32'(cyc), 32'(mon_e.cyc));
                check("rsp_write", 32'(bus.rsp_write), 32'(mon_e.wr));
                if (mon_e.chk_rdata) check("rsp_rdata", 32'(bus.rsp_rdata), 32'(mon_e.rdata));
                check("rsp_err", 32'(bus.rsp_err), 32'(mon_e.err));
            end
        end
    end

    // mode: 0 normal, 1 hold valid and change addr mid-FETCH, 2 reset during DRIVE
    task automatic do_req(input logic wr, input logic [3:0] addr, input logic [7:0] data, input int mode);
        int   waited = 0;
        exp_t e;
        while (bus.req_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 20) begin
            check("req_ready_timeout", 32'd0, 32'd1);
            return;
        end
        acc_with_rsp  = bus.rsp_valid;
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_wdata = data;
        e.wr  = wr;
        e.cyc = cyc + 1 + (wr ? WLAT : 2);
`ifdef MEM_CTRL_WVERIFY_EN
        e.err       = wr & corrupt;
        e.rdata     = wr ? (data ^ {7'd0, corrupt}) : exp_mem[addr];
        e.chk_rdata = 1'b1;
`else
        e.err       = 1'b0;
        e.rdata     = exp_mem[addr];
        e.chk_rdata = !wr;
`endif
        if (wr) exp_mem[addr] = data;
        if (mode != 2) sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        check("acc_cs", 32'(bus.mem_cs), 32'd1);
        check("acc_we", 32'(bus.mem_write_en), 32'(wr));
        check("acc_re", 32'(bus.mem_read_en), 32'd0);
        check("acc_addr", 32'(bus.mem_address), 32'(addr));
        if (wr) check("acc_wdata", 32'(bus.mem_data_out), 32'(data));
        if (mode == 1) begin
            bus.req_addr = addr + 4'd1;
        end else begin
            bus.req_valid = 1'b0;
            bus.req_write = 1'($urandom);
            bus.req_addr  = 4'($urandom);
            bus.req_wdata = 8'($urandom);
        end
`ifdef MEM_CTRL_WVERIFY_EN
        if (wr) begin
            @(negedge clk);
            check("vfetch_re", 32'(bus.mem_read_en), 32'd0);
            check("vfetch_we", 32'(bus.mem_write_en), 32'd0);
            @(negedge clk);
            check("vdrive_re", 32'(bus.mem_read_en), 32'd1);
            check("vdrive_addr", 32'(bus.mem_address), 32'(addr));
        end
`endif
        if (!wr) begin
            @(negedge clk);
            check("drive_cs", 32'(bus.mem_cs), 32'd1);
            check("drive_re", 32'(bus.mem_read_en), 32'd1);
            check("drive_addr", 32'(bus.mem_address), 32'(addr));
            if (mode == 2) begin
                rst = 1'b1;
                @(posedge clk);
                @(negedge clk);
                rst = 1'b0;
                check("rstd_ready", 32'(bus.req_ready), 32'd1);
                check("rstd_rsp_valid", 32'(bus.rsp_valid), 32'd0);
                check("rstd_rdata", 32'(bus.rsp_rdata), 32'h00);
                check("rstd_cs", 32'(bus.mem_cs), 32'd0);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem[i]     = 8'h00;
            exp_mem[i] = 8'h00;
        end
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(bus.req_ready), 32'd1);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rdata", 32'(bus.rsp_rdata), 32'h00);
        check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        check("rst_mem_ctl", 32'({bus.mem_cs, bus.mem_write_en, bus.mem_read_en}), 32'd0);
        check("rst_mem_bus", 32'({bus.mem_address, bus.mem_data_out}), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        do_req(1'b1, 4'd0, 8'h8A, 0);
        do_req(1'b1, 4'd1, 8'hEA, 0);
        do_req(1'b1, 4'd2, 8'hCE, 0);
        do_req(1'b1, 4'd3, 8'hAA, 0);
        for (int a = 0; a < 4; a++) do_req(1'b0, 4'(a), 8'h00, 0);

        do_req(1'b0, 4'd2, 8'h00, 1);
        do_req(1'b0, 4'd3, 8'h00, 0);
        check("b2b_accept_in_rsp", 32'(acc_with_rsp), 32'd1);

        do_req(1'b0, 4'd0, 8'h00, 2);
        do_req(1'b0, 4'd1, 8'h00, 0);

        do_req(1'b1, 4'd15, 8'h3C, 0);
        do_req(1'b0, 4'd15, 8'h00, 0);

`ifdef MEM_CTRL_WVERIFY_EN
        do_req(1'b1, 4'd15, 8'h5C, 0);
        corrupt = 1'b1;
        do_req(1'b1, 4'd15, 8'h5C, 0);
        repeat (3) @(negedge clk);
        corrupt = 1'b0;
        do_req(1'b0, 4'd15, 8'h00, 0);
`endif

        repeat (6) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/memory_access_controller.md
# memory_access_controller

Request-side initiator for the single-port `cs`/`write_en`/`read_en` scratch memory. It accepts one read or write request at a time over a valid/ready handshake and sequences the memory's chip-select, write-enable and read-enable pins. For reads it runs the memory's two-phase fetch/drive protocol and returns the captured word as a one-cycle response pulse. It sits between a processing block and the memory instance, owns all memory control pins, and only samples the memory's tri-stated output bus during its drive phase.

## Interface
- `data_size`, default 8: width of the data word.
- `address`, default 4: width of the address; memory depth is 2^`address`.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller can accept; high only in IDLE.
- `req_write`  in  1  1 = write, 0 = read.
- `req_addr`  in  `address`  target address.
- `req_wdata`  in  `data_size`  write data.
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_write`  out  1  completed request was a write.
- `rsp_rdata`  out  `data_size`  read data; held until the next capture.
- `rsp_err`  out  1  readback mismatch; see Configuration.
- `mem_cs`  out  1  memory chip select.
- `mem_write_en`  out  1  memory write enable.
- `mem_read_en`  out  1  memory output enable.
- `mem_address`  out  `address`  memory address.
- `mem_data_out`  out  `data_size`  to memory `data_in`.
- `mem_data_in`  in  `data_size`  from memory `data_out`; Z outside the drive phase.

## Operation
- States: IDLE, WRITE, FETCH, DRIVE. With `MEM_CTRL_WVERIFY_EN` defined, VFETCH and VDRIVE are added.
- IDLE: `req_ready`=1 and `mem_cs`/`mem_write_en`/`mem_read_en`=0. On `req_valid && req_ready`, latch `req_write`, `req_addr` and `req_wdata`. Go to WRITE if `req_write`=1, otherwise go to FETCH.
- WRITE: `mem_cs`=1, `mem_write_en`=1, `mem_read_en`=0. Latched address and data are driven. Next state is IDLE, or VFETCH in verify mode.
- FETCH and VFETCH: `mem_cs`=1, `mem_write_en`=0, `mem_read_en`=0. The memory loads its output latch at the closing edge.
- DRIVE and VDRIVE: `mem_cs`=1, `mem_write_en`=0, `mem_read_en`=1. `mem_data_in` is registered into `rsp_rdata` at the closing edge. Next state is IDLE.
- `rsp_valid` is registered and pulses for exactly one cycle, in the IDLE cycle after the last access state. `rsp_write` is valid only with `rsp_valid`.
- `mem_address` and `mem_data_out` hold their last latched values while in IDLE.
- `mem_data_in` is never used outside DRIVE or VDRIVE, so X/Z on it elsewhere is legal.
- `req_*` inputs are ignored outside the accepting edge, and their changes mid-transaction have no effect.

## Timing
- All outputs are registered or decoded from the state register, with no combinational path from `req_*` to any `mem_*` pin.
- Reset values: state IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_write`=0, `rsp_err`=0, `rsp_rdata`=0, all `mem_*` outputs 0.
- The accept edge is edge T.
  - Write: WRITE runs during T..T+1, the memory stores at T+1, and `rsp_valid` is high during T+1..T+2. The next accept is at T+2 at the earliest.
  - Read: FETCH runs during T..T+1, DRIVE during T+1..T+2, capture happens at T+2, and `rsp_valid` is high during T+2..T+3. The next accept is at T+3 at the earliest.
- `req_ready` is high during the `rsp_valid` cycle, so back-to-back requests overlap the response pulse.
- `rst` in any state returns the controller to IDLE on that edge with reset values. The in-flight request is dropped with no `rsp_valid`. A write that already hit its memory edge stays written.
- Address wrap: the address is exactly `address` bits with no range check, so every code is a valid location.

## Configuration
- `MEM_CTRL_WVERIFY_EN` defined: every write is followed by VFETCH and VDRIVE at the same address.
  - Completion comes 3 cycles after accept.
  - `rsp_rdata` takes the readback value.
  - `rsp_err` is 1 with `rsp_valid` when the readback differs from the latched write data, otherwise 0.
  - Reads are unchanged, with `rsp_err`=0.
- Undefined: writes complete in 1 cycle after accept, VFETCH and VDRIVE do not exist, `rsp_rdata` is untouched by writes, and `rsp_err` is tied to 0.

## Test plan
- Reset, then idle: `req_ready`=1, all `mem_*`=0, `rsp_valid`=0, `rsp_rdata`=0x00.
- Write 0x8A@0, 0xEA@1, 0xCE@2, 0xAA@3 back-to-back. Expect each WRITE cycle to show `mem_cs`=1, `mem_write_en`=1 and the correct address/data. Expect `rsp_valid`, with `rsp_write`=1, one cycle after each accept.
- Read addresses 0..3. Expect a FETCH cycle with `mem_read_en`=0, then a DRIVE cycle with `mem_read_en`=1. Expect `rsp_rdata` = 0x8A, 0xEA, 0xCE, 0xAA respectively, two cycles after each accept.
- Hold `req_valid`=1 during a read and change `req_addr` mid-FETCH. Expect the original address to be used and exactly one response, with the next request accepted during the `rsp_valid` cycle.
- Assert `rst` in DRIVE. Expect IDLE on the next edge, no `rsp_valid`, and `rsp_rdata` reset to 0x00; a subsequent read of address 1 returns 0xEA.
- With `MEM_CTRL_WVERIFY_EN`: write 0x5C@15 and expect `rsp_valid` 3 cycles after accept with `rsp_rdata`=0x5C and `rsp_err`=0. Force the memory model to return 0x5D in VDRIVE and expect `rsp_err`=1.
